// File: rtl/cic_ctrl.sv
// Sequencing controller for a decimating CIC filter: owns clear/enable/rate,
// accepts rate changes over a valid/ready handshake and drops settling outputs.
module cic_ctrl #(
    parameter int MAX_DEC_RATE   = 8,
    parameter int DEC_W          = $clog2($clog2(MAX_DEC_RATE + 1)),
    parameter int DATA_WIDTH     = 8,
    parameter int SETTLE_OUTPUTS = 3,
    parameter int DEFAULT_DEC    = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [DEC_W-1:0]             cfg_dec_factor,
    output logic                         cfg_err,
    input  logic                         in_valid,
    output logic                         cic_clear,
    output logic                         cic_enable,
    output logic                         cic_data_in_ready,
    output logic [DEC_W-1:0]             cic_dec_factor,
    input  logic                         cic_data_out_ready,
    input  logic signed [DATA_WIDTH-1:0] cic_data_out,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic                         settled,
    output logic [CNT_WIDTH-1:0]         out_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;

    localparam logic [31:0] MAX_CODE    = 32'($clog2(MAX_DEC_RATE));
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_OUTPUTS - 1);

    function automatic logic code_legal(input logic [DEC_W-1:0] code);
        return 32'(code) <= MAX_CODE;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [DEC_W-1:0] dec_reg;
    logic [3:0]       settle_cnt;
    logic             cfg_fire;
    logic             cfg_take;
    logic             cfg_bad;
    logic             fwd;

    always_comb begin
        cfg_ready         = (state != CLEAR);
        cfg_fire          = cfg_valid & cfg_ready;
        cfg_take          = cfg_fire & code_legal(cfg_dec_factor);
        cfg_bad           = cfg_fire & ~code_legal(cfg_dec_factor);
        cic_clear         = (state == CLEAR);
        cic_enable        = (state == SETTLE) || (state == RUN);
        cic_data_in_ready = in_valid & cic_enable;
        cic_dec_factor    = dec_reg;
        busy              = (state != IDLE);
        settled           = (state == RUN);
        fwd               = (state == RUN) & cic_data_out_ready;
    end

    // Next state: stop beats an accepted rate change, which beats start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!cfg_take && start) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = stop ? IDLE : SETTLE;
            end
            SETTLE: begin
                if (stop)                  state_next = IDLE;
                else if (cfg_take)         state_next = CLEAR;
                else if (cic_data_out_ready && settle_cnt == SETTLE_LAST)
                                           state_next = RUN;
            end
            RUN: begin
                if (stop)          state_next = IDLE;
                else if (cfg_take) state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dec_reg    <= DEC_W'(DEFAULT_DEC);
            settle_cnt <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state   <= state_next;
            cfg_err <= cfg_bad;
            if (cfg_take) dec_reg <= cfg_dec_factor;
            if (state == CLEAR)
                settle_cnt <= '0;
            else if (state == SETTLE && cic_data_out_ready)
                settle_cnt <= settle_cnt + 4'd1;
        end
    end

    // Output stage: one-cycle registered forward; count restarts on every clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            out_valid <= fwd;
            if (fwd) out_data <= cic_data_out;
            if (state_next == CLEAR || state == CLEAR)
                out_count <= '0;
            else if (fwd)
                out_count <= out_count + 1'b1;
        end
    end

endmodule
